histogram_frame_ctrl: RTL
=========================

// Module: histogram_frame_ctrl
// PURPOSE
//  Frame sequencer in front of histogram_calc. Accepts a host start command and an AXI-Stream pixel
//  stream, and gates exactly cfg_frame_len pixels into the core as rx_valid beats, then one rx_done pulse.
//  Forwards the core's bin readout to a downstream AXI-Stream master and checks its bin count.
//  Reports busy/done and sticky error flags to the host.
// PARAMETERS
//  P_DW       3   pixel width (= histogram_calc P_DW)
//  P_NUM_BIN  8   bins emitted by core per frame
//  P_CW       3   bin-count beat width (= histogram_calc output width)
//  P_LW       16  frame-length counter width
// PORTS
//  aclk            in   1      clock
//  areset_n        in   1      async active-low reset
//  start           in   1      1-cycle pulse, begin frame (ignored unless IDLE)
//  abort           in   1      sync abort, any state -> IDLE
//  cfg_frame_len   in   P_LW   pixels per frame, sampled on accepted start
//  s_tdata         in   P_DW   pixel in
//  s_tvalid        in   1      pixel valid
//  s_tlast         in   1      upstream end-of-frame marker
//  s_tready        out  1      pixel accepted
//  histo_ready     in   1      core idle/ready
//  histo_data_i    out  P_DW   pixel to core (registered)
//  rx_valid        out  1      pixel strobe to core (registered)
//  rx_done         out  1      end-of-frame pulse to core
//  core_tdata      in   P_CW   core histo_data_o
//  core_tvalid     in   1      core histo_data_valid
//  core_tlast      in   1      core histo_data_last
//  core_tready     out  1      to core tready
//  m_tdata/m_tvalid/m_tlast  out  P_CW/1/1   bin stream out
//  m_tready        in   1      downstream ready
//  busy            out  1      high in every state except IDLE
//  done            out  1      1-cycle pulse at frame completion
//  err_flags       out  4      sticky {err_bins, err_long, err_short, err_cfg}; cleared by accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, err_flags 0.
//  IDLE: start & cfg_frame_len!=0 -> latch len, clear err_flags, go WAIT_RDY; start & len==0 -> set err_cfg, stay IDLE.
//  WAIT_RDY: histo_ready==1 -> ACCUM (earliest next cycle).
//  ACCUM: s_tready=1. Each s_tvalid&s_tready beat registers histo_data_i<=s_tdata, rx_valid<=1 (1-cycle latency);
//    otherwise rx_valid<=0. pix_cnt increments per beat, wraps at no point (saturates at len).
//    Beat with pix_cnt==len-1 -> FLUSH; if s_tlast==0 on that beat set err_long (excess upstream pixels are not
//    consumed by this block).
//    s_tlast on a beat with pix_cnt<len-1 -> set err_short, go FLUSH (the short frame is still closed).
//  FLUSH: s_tready=0; rx_done=1 for exactly one cycle, the cycle after the last rx_valid; -> READOUT.
//  READOUT: m_tdata/m_tvalid/m_tlast = core_t* and core_tready = m_tready (combinational pass-through).
//    bin_cnt counts core_tvalid&m_tready beats. Beat with core_tlast -> DONE; if bin_cnt!=P_NUM_BIN-1 set err_bins.
//    Beat with bin_cnt==P_NUM_BIN-1 and no core_tlast: set err_bins, -> DONE.
//  DONE: done=1 for one cycle -> IDLE.
//  Outside READOUT: m_tvalid=0, core_tready=0. Outside ACCUM: s_tready=0.
//  abort: wins over all transitions; next cycle IDLE, rx_valid/rx_done/done=0, counters cleared, err_flags held.
//  start while busy: ignored, no flag.
//  Simultaneous start & abort in IDLE: abort wins (stay IDLE).
// CONFIGURATION
//  HISTO_FRAME_TIMEOUT_EN defined: P_TO_CYC (default 1024) watchdog, reloaded on every accepted beat in ACCUM and READOUT
//    and on each WAIT_RDY cycle with histo_ready=1. Expiry in WAIT_RDY/ACCUM/READOUT -> IDLE as for abort,
//    with err_flags widened to 5 bits, bit4 = err_timeout.
//  Undefined: no watchdog logic; err_flags is 4 bits; a stalled stream waits indefinitely.
// STRUCTURE
//  histogram_pkg: state enum {IDLE,WAIT_RDY,ACCUM,FLUSH,READOUT,DONE}, err_flags bit indices, clog2 width constants.
//  One sub-module histo_beat_cnt (load/inc/clear, terminal-count compare), used for both pix_cnt and bin_cnt.
// TESTING (P_DW=3, P_NUM_BIN=8, P_CW=3)
//  1 Nominal: len=10, 10 pixels, s_tlast on 10th -> 10 rx_valid beats, rx_done 1 cycle later, 8 bins forwarded,
//    done pulse, err_flags=0.
//  2 Backpressure: m_tready toggles 2-on/2-off during READOUT -> m_t* mirror core, no bin lost/duplicated,
//    m_tlast on 8th beat.
//  3 Short frame: len=10, s_tlast on pixel 6 -> 6 rx_valid beats, rx_done, err_short=1; readout still completes.
//  4 Long/cfg: len=4 with no s_tlast by pixel 4 -> err_long=1, s_tready=0 after 4th beat;
//    start with len=0 -> err_cfg=1, busy stays 0.
//  5 Abort mid-ACCUM after 3 pixels -> IDLE next cycle, no rx_done, busy=0; a following start runs frame 1 cleanly.
//  6 HISTO_FRAME_TIMEOUT_EN, s_tvalid held 0 in ACCUM for 1024 cycles -> err_timeout=1, IDLE.

Source files
------------

// File: rtl/histogram_pkg.sv
// rtl/histogram_pkg.sv - states, err_flags bit indices and width helpers for histogram_frame_ctrl
// HISTO_FRAME_TIMEOUT_EN adds ERR_TIMEOUT and widens err_flags to 5 bits.
package histogram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ACCUM,
        FLUSH,
        READOUT,
        DONE
    } state_e;

    localparam int ERR_CFG   = 0;
    localparam int ERR_SHORT = 1;
    localparam int ERR_LONG  = 2;
    localparam int ERR_BINS  = 3;
`ifdef HISTO_FRAME_TIMEOUT_EN
    localparam int ERR_TIMEOUT = 4;
    localparam int ERR_W       = 5;
`else
    localparam int ERR_W       = 4;
`endif

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/histo_beat_cnt.sv
// rtl/histo_beat_cnt.sv - beat counter with loadable terminal value and terminal-count flag
module histo_beat_cnt #(
    parameter int P_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clear,
    input  logic           i_load,
    input  logic [P_W-1:0] i_term,
    input  logic           i_inc,
    output logic           o_tc
);

    logic [P_W-1:0] r_cnt;
    logic [P_W-1:0] r_term;

    // Load restarts the count and latches the terminal value; increments saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_term <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_term <= i_term;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == r_term);

endmodule

// File: rtl/histogram_frame_ctrl.sv
// rtl/histogram_frame_ctrl.sv - frame sequencer gating pixels into histogram_calc and forwarding its bins
// HISTO_FRAME_TIMEOUT_EN enables the stall watchdog (P_TO_CYC) and err_flags bit 4.
module histogram_frame_ctrl
    import histogram_pkg::*;
#(
    parameter int P_DW      = 3,
    parameter int P_NUM_BIN = 8,
    parameter int P_CW      = 3,
    parameter int P_LW      = 16
`ifdef HISTO_FRAME_TIMEOUT_EN
    ,
    parameter int P_TO_CYC  = 1024
`endif
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [P_LW-1:0]  cfg_frame_len,
    input  logic [P_DW-1:0]  s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    input  logic             histo_ready,
    output logic [P_DW-1:0]  histo_data_i,
    output logic             rx_valid,
    output logic             rx_done,
    input  logic [P_CW-1:0]  core_tdata,
    input  logic             core_tvalid,
    input  logic             core_tlast,
    output logic             core_tready,
    output logic [P_CW-1:0]  m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_flags
);

    localparam int LP_BW = cnt_w(P_NUM_BIN);

    state_e            r_state;
    state_e            w_next;
    logic [ERR_W-1:0]  r_err;
    logic [ERR_W-1:0]  w_err_set;
    logic [P_DW-1:0]   r_histo_data;
    logic              r_rx_valid;
    logic              r_rx_done;
    logic              w_beat_s;
    logic              w_beat_m;
    logic              w_pix_tc;
    logic              w_bin_tc;
    logic              w_start_ok;
    logic              w_kill;
    logic              w_expire;

    assign w_beat_s   = (r_state == ACCUM) && s_tvalid;
    assign w_beat_m   = (r_state == READOUT) && core_tvalid && m_tready;
    assign w_start_ok = (r_state == IDLE) && start && !abort && (cfg_frame_len != '0);
    assign w_kill     = abort || w_expire;

    histo_beat_cnt #(.P_W(P_LW)) u_pix_cnt (
        .clk     (aclk),
        .rst_n   (areset_n),
        .i_clear (w_kill),
        .i_load  (w_start_ok),
        .i_term  (cfg_frame_len - 1'b1),
        .i_inc   (w_beat_s),
        .o_tc    (w_pix_tc)
    );

    histo_beat_cnt #(.P_W(LP_BW)) u_bin_cnt (
        .clk     (aclk),
        .rst_n   (areset_n),
        .i_clear (w_kill),
        .i_load  (w_start_ok),
        .i_term  (LP_BW'(P_NUM_BIN - 1)),
        .i_inc   (w_beat_m),
        .o_tc    (w_bin_tc)
    );

`ifdef HISTO_FRAME_TIMEOUT_EN
    localparam int LP_TW = cnt_w(P_TO_CYC);
    logic [LP_TW-1:0] r_to_cnt;
    logic             w_to_watch;
    logic             w_to_reload;

    assign w_to_watch  = (r_state == WAIT_RDY) || (r_state == ACCUM) || (r_state == READOUT);
    assign w_to_reload = !w_to_watch || w_beat_s || w_beat_m ||
                         ((r_state == WAIT_RDY) && histo_ready);
    assign w_expire    = w_to_watch && !w_to_reload && (r_to_cnt == '0);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_to_cnt <= LP_TW'(P_TO_CYC - 1);
        end else if (w_to_reload || abort) begin
            r_to_cnt <= LP_TW'(P_TO_CYC - 1);
        end else if (r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_err_set = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (cfg_frame_len != '0) w_next = WAIT_RDY;
                    else                     w_err_set[ERR_CFG] = 1'b1;
                end
            end
            WAIT_RDY: if (histo_ready) w_next = ACCUM;
            ACCUM: begin
                // Reaching len closes the frame even without s_tlast; an early s_tlast closes it short.
                if (w_beat_s) begin
                    if (w_pix_tc) begin
                        w_next = FLUSH;
                        if (!s_tlast) w_err_set[ERR_LONG] = 1'b1;
                    end else if (s_tlast) begin
                        w_next = FLUSH;
                        w_err_set[ERR_SHORT] = 1'b1;
                    end
                end
            end
            FLUSH: w_next = READOUT;
            READOUT: begin
                if (w_beat_m) begin
                    if (core_tlast) begin
                        w_next = DONE;
                        if (!w_bin_tc) w_err_set[ERR_BINS] = 1'b1;
                    end else if (w_bin_tc) begin
                        w_next = DONE;
                        w_err_set[ERR_BINS] = 1'b1;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_kill) begin
            w_next    = IDLE;
            w_err_set = '0;
        end
`ifdef HISTO_FRAME_TIMEOUT_EN
        if (w_expire && !abort) w_err_set[ERR_TIMEOUT] = 1'b1;
`endif
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state      <= IDLE;
            r_err        <= '0;
            r_histo_data <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_done    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err      <= w_start_ok ? '0 : (r_err | w_err_set);
            r_rx_valid <= w_beat_s && !abort;
            r_rx_done  <= (r_state == FLUSH) && !abort;
            if (w_beat_s) r_histo_data <= s_tdata;
        end
    end

    assign s_tready     = (r_state == ACCUM);
    assign histo_data_i = r_histo_data;
    assign rx_valid     = r_rx_valid;
    assign rx_done      = r_rx_done;
    assign core_tready  = (r_state == READOUT) && m_tready;
    assign m_tvalid     = (r_state == READOUT) && core_tvalid;
    assign m_tlast      = (r_state == READOUT) && core_tlast;
    assign m_tdata      = (r_state == READOUT) ? core_tdata : '0;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign err_flags    = r_err;

endmodule
